bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter placed directly upstream of the SoC mmu.
- Master 0 is the bexkat2 CPU; master 1 is a second bus master (DMA / blitter).
- Muxes one granted master onto the single address/read/write/data/byteenable/waitrequest bus feeding the mmu, which then decodes chipselect.
- Uses round-robin fairness and holds the grant for exactly one transfer.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byteenable width is DW/8.
- TIMEOUT, 1024, slave wait cycles before forced completion (used only with ARB_TIMEOUT_EN).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- m0_address  in  AW  master 0 address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DW  master 0 write data.
- m0_byteenable  in  DW/8  master 0 byte enables.
- m0_readdata  out  DW  master 0 read data.
- m0_waitrequest  out  1  master 0 stall.
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_readdata, m1_waitrequest: same as m0_*, for master 1.
- s_address  out  AW  to mmu address.
- s_read  out  1  to mmu read_in.
- s_write  out  1  to mmu write_in.
- s_writedata  out  DW  slave write data.
- s_byteenable  out  DW/8  slave byte enables.
- s_readdata  in  DW  slave read data.
- s_waitrequest  in  1  from mmu wait_out.
- grant  out  2  one-hot current grant: 01 is m0, 10 is m1, 00 is idle.
- timeout  out  1  one-cycle pulse on forced completion.

Behaviour:
- Protocol:
  - A master holds its request and signals stable until a cycle with request=1 and waitrequest=0. That cycle is the completion cycle.
  - Read data is valid on the completion cycle.
  - Read and write asserted together is illegal; write wins, so s_read = read & ~write.
- States: IDLE, GNT0, GNT1; grant register plus a last-granted register, last.
- IDLE:
  - Both requesting: grant the master not equal to last.
  - One requesting: grant it.
  - Transitions to GNTx on the next edge.
- GNTx:
  - s_* = mx_* combinationally (mux selected by the registered state).
  - mx_waitrequest = s_waitrequest; mx_readdata = s_readdata.
  - The other master sees waitrequest=1 and readdata=0.
- Completion in GNTx: last <= x and next state IDLE. One IDLE cycle always separates transfers.
  - Back-to-back traffic from a single master therefore costs 1 arbitration cycle plus slave latency per transfer.
- Granted master drops its request before completion (protocol violation): next state IDLE; last is not updated.
- In IDLE:
  - s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0.
  - Both m*_waitrequest = 1; both m*_readdata = 0.
- Latency: request first seen in IDLE at cycle t; slave sees the request at t+1; the earliest completion is t+1 if s_waitrequest is low.
- Reset (any cycle, including mid-transfer):
  - State IDLE, last = 1 (so m0 wins the first contention), grant = 00, timeout = 0.
  - All s_* outputs 0; both waitrequests 1.
  - An in-flight transfer is abandoned and not completed to the master.
- grant reflects the state register; it is 00 in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GNTx and increments each GNTx cycle with s_waitrequest=1.
  - When the counter equals TIMEOUT-1 and s_waitrequest is still 1, the arbiter forces completion:
    - mx_waitrequest = 0 and mx_readdata = 0 for that cycle.
    - s_read = s_write = 0 that cycle.
    - timeout pulses 1 for one cycle.
    - Next state IDLE and last <= x.
  - The counter clears on reset and in IDLE.
- Undefined: no counter; timeout is tied 0; a stalled slave stalls the granted master indefinitely.

Test Plan:
- Reset, then m0_read=1 at address 0x00000010 with s_waitrequest=0:
  - Cycle 1: grant=01 and s_read=1, s_address=0x10.
  - The same cycle, m0_waitrequest=0 and m0_readdata=s_readdata (0xCAFEF00D).
  - Cycle 2: grant=00.
- m0_write and m1_write asserted in the same cycle after reset:
  - m0 is granted first.
  - After completion there is one IDLE cycle, then m1 is granted.
  - s_writedata matches each master's writedata; m1_waitrequest=1 throughout GNT0.
- Both masters requesting continuously for 8 transfers: grants alternate 01,10,01,10,... with each grant separated by one 00 cycle.
- Slave holds s_waitrequest=1 for 5 cycles during an m1 read:
  - m1_waitrequest=1 for those 5 cycles, then 0.
  - m0 (requesting) stays stalled with readdata=0.
- reset asserted on the 3rd wait cycle of an m0 write: next cycle all s_* = 0, grant=00, both waitrequests 1; after release, m0 is re-granted.
- ARB_TIMEOUT_EN, TIMEOUT=16, s_waitrequest stuck 1:
  - In GNT0 cycle 16, m0_waitrequest=0, m0_readdata=0 and timeout=1 for exactly 1 cycle.
  - Then the arbiter returns to IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter feeding the mmu; each grant covers one transfer.
// Define ARB_TIMEOUT_EN to add a slave-stall watchdog that forces completion after TIMEOUT waits.
module bus_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            reset,

  input  logic [AW-1:0]   m0_address,
  input  logic            m0_read,
  input  logic            m0_write,
  input  logic [DW-1:0]   m0_writedata,
  input  logic [DW/8-1:0] m0_byteenable,
  output logic [DW-1:0]   m0_readdata,
  output logic            m0_waitrequest,

  input  logic [AW-1:0]   m1_address,
  input  logic            m1_read,
  input  logic            m1_write,
  input  logic [DW-1:0]   m1_writedata,
  input  logic [DW/8-1:0] m1_byteenable,
  output logic [DW-1:0]   m1_readdata,
  output logic            m1_waitrequest,

  output logic [AW-1:0]   s_address,
  output logic            s_read,
  output logic            s_write,
  output logic [DW-1:0]   s_writedata,
  output logic [DW/8-1:0] s_byteenable,
  input  logic [DW-1:0]   s_readdata,
  input  logic            s_waitrequest,

  output logic [1:0]      grant,
  output logic            timeout
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;  // 0: m0 was served last, 1: m1

  logic            req0, req1;
  logic            busy, sel;
  logic            sel_req, sel_read, sel_write;
  logic [AW-1:0]   sel_address;
  logic [DW-1:0]   sel_writedata;
  logic [DW/8-1:0] sel_byteenable;
  logic            sel_wait;
  logic [DW-1:0]   sel_rdata;
  logic            force_done;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign busy = (state_q != StIdle);
  assign sel  = (state_q == StGnt1);

  assign sel_req        = sel ? req1           : req0;
  assign sel_read       = sel ? m1_read        : m0_read;
  assign sel_write      = sel ? m1_write       : m0_write;
  assign sel_address    = sel ? m1_address     : m0_address;
  assign sel_writedata  = sel ? m1_writedata   : m0_writedata;
  assign sel_byteenable = sel ? m1_byteenable  : m0_byteenable;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_done = busy && sel_req && s_waitrequest && (cnt_q == CW'(TIMEOUT - 1));

  // Counter is zero whenever idle, so every grant starts counting from zero.
  always_comb begin
    cnt_d = '0;
    if (busy && sel_req && s_waitrequest && !force_done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign force_done     = 1'b0;
`endif

  assign timeout = force_done;
  assign grant   = {state_q == StGnt1, state_q == StGnt0};

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    sel_wait       = 1'b1;
    sel_rdata      = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;

    unique case (state_q)
      StIdle: begin
        if (req0 && (!req1 || last_q)) begin
          state_d = StGnt0;
        end else if (req1) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        s_address    = sel_address;
        s_writedata  = sel_writedata;
        s_byteenable = sel_byteenable;
        s_write      = sel_write & ~force_done;
        s_read       = sel_read & ~sel_write & ~force_done;
        sel_wait     = s_waitrequest & ~force_done;
        sel_rdata    = force_done ? '0 : s_readdata;
        // A dropped request abandons the grant without counting as service.
        if (!sel_req) begin
          state_d = StIdle;
        end else if (!sel_wait) begin
          state_d = StIdle;
          last_d  = sel;
        end
      end
      default: state_d = StIdle;
    endcase

    // Hold the master stalled during reset so an abandoned transfer never completes.
    if (sel) begin
      m1_waitrequest = sel_wait | reset;
      m1_readdata    = sel_rdata;
    end else begin
      m0_waitrequest = sel_wait | reset;
      m0_readdata    = sel_rdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter; expected transfers are queued per master
// when requested and checked at the slave-side completion cycle.
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } xfer_t;

  xfer_t q0[$];
  xfer_t q1[$];
  int    checks   = 0;
  int    failures = 0;

  bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest),
    .grant          (grant),
    .timeout        (timeout)
  );

  always #5 clock = ~clock;

  // Slave returns an address-dependent word; address 0x10 reads 0xCAFEF00D.
  assign s_readdata = 32'hCAFEF00D ^ (s_address - 32'h10);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic master_xfer(input int m, input logic wr, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata, output int lat);
    xfer_t e;
    logic  done;
    e.wr   = wr;
    e.addr = addr;
    e.be   = be;
    e.data = wr ? wdata : (32'hCAFEF00D ^ (addr - 32'h10));
    if (m == 0) begin
      q0.push_back(e);
      m0_address = addr; m0_byteenable = be; m0_writedata = wdata;
      m0_write = wr; m0_read = !wr;
    end else begin
      q1.push_back(e);
      m1_address = addr; m1_byteenable = be; m1_writedata = wdata;
      m1_write = wr; m1_read = !wr;
    end
    lat  = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      lat++;
      done = (m == 0) ? !m0_waitrequest : !m1_waitrequest;
    end
    check("xfer_done", 32'(done), 32'd1);
    @(posedge clock);
    #1;
    if (m == 0) begin
      m0_read = 1'b0; m0_write = 1'b0;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0;
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_waitrequest = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_rw", 32'({s_read, s_write}), 32'd0);
    check("rst_s_addr", s_address, 32'd0);
    check("rst_s_wdata", s_writedata, 32'd0);
    check("rst_s_be", 32'(s_byteenable), 32'd0);
    check("rst_mwait", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
    check("rst_timeout", 32'(timeout), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: idle/other-master invariants and scoreboard pop on slave completion.
  always @(negedge clock) begin : mon
    xfer_t       e;
    logic [31:0] rd;
    if (!reset) begin
      check("grant_onehot", 32'($onehot0(grant)), 32'd1);
      if (grant == 2'b00) begin
        check("idle_s_rw", 32'({s_read, s_write}), 32'd0);
        check("idle_s_addr", s_address, 32'd0);
        check("idle_mwait", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
        check("idle_rdata", m0_readdata | m1_readdata, 32'd0);
      end else if (grant == 2'b01) begin
        check("gnt0_m1_wait", 32'(m1_waitrequest), 32'd1);
        check("gnt0_m1_rdata", m1_readdata, 32'd0);
      end else if (grant == 2'b10) begin
        check("gnt1_m0_wait", 32'(m0_waitrequest), 32'd1);
        check("gnt1_m0_rdata", m0_readdata, 32'd0);
      end
      if ((s_read || s_write) && !s_waitrequest && grant != 2'b00) begin
        if ((grant == 2'b01 && q0.size() == 0) || (grant == 2'b10 && q1.size() == 0)) begin
          check("sb_unexpected", 32'(grant), 32'd0);
        end else begin
          if (grant == 2'b01) e = q0.pop_front();
          else                e = q1.pop_front();
          rd = (grant == 2'b01) ? m0_readdata : m1_readdata;
          check("sb_addr", s_address, e.addr);
          check("sb_wr", 32'(s_write), 32'(e.wr));
          check("sb_be", 32'(s_byteenable), 32'(e.be));
          check("sb_mwait", 32'((grant == 2'b01) ? m0_waitrequest : m1_waitrequest), 32'd0);
          if (e.wr) check("sb_wdata", s_writedata, e.data);
          else      check("sb_rdata", rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int l0, l1;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    s_waitrequest = 1'b0;

    // Single m0 read, zero-wait slave.
    reset_dut();
    fork
      master_xfer(0, 1'b0, 32'h10, 4'hF, 32'd0, l0);
      begin
        @(negedge clock);
        check("rd_gnt_c0", 32'(grant), 32'd0);
        @(negedge clock);
        check("rd_gnt_c1", 32'(grant), 32'd1);
        check("rd_s_read", 32'(s_read), 32'd1);
        check("rd_s_addr", s_address, 32'h10);
        check("rd_m0_wait", 32'(m0_waitrequest), 32'd0);
        check("rd_m0_rdata", m0_readdata, 32'hCAFEF00D);
        @(negedge clock);
        check("rd_gnt_c2", 32'(grant), 32'd0);
      end
    join
    check("rd_lat", l0, 32'd2);

    // Simultaneous writes: m0 first, one idle cycle, then m1.
    reset_dut();
    fork
      master_xfer(0, 1'b1, 32'h100, 4'hF, 32'h11112222, l0);
      master_xfer(1, 1'b1, 32'h180, 4'h3, 32'h33334444, l1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        check("wr2_gnt", 32'(grant), (i == 1) ? 32'd1 : (i == 3) ? 32'd2 : 32'd0);
      end
    join
    check("wr2_lat0", l0, 32'd2);
    check("wr2_lat1", l1, 32'd4);

    // Continuous contention, 8 transfers: grants alternate with an idle cycle between.
    reset_dut();
    fork
      for (int k = 0; k < 4; k++) master_xfer(0, 1'b0, 32'(32'h1000 + k * 4), 4'hF, 32'd0, l0);
      for (int k = 0; k < 4; k++)
        master_xfer(1, 1'b1, 32'(32'h2000 + k * 4), 4'h5, 32'(32'hA5A50000 + k), l1);
      for (int i = 0; i < 17; i++) begin
        @(negedge clock);
        check("rr_gnt", 32'(grant), (i % 4 == 1) ? 32'd1 : (i % 4 == 3) ? 32'd2 : 32'd0);
      end
    join

    // m1 read stalled 5 cycles while m0 waits behind it.
    reset_dut();
    s_waitrequest = 1'b1;
    fork
      master_xfer(1, 1'b0, 32'h200, 4'hF, 32'd0, l1);
      begin
        @(posedge clock);
        #1;
        master_xfer(0, 1'b0, 32'h300, 4'hC, 32'd0, l0);
      end
      begin
        repeat (6) @(posedge clock);
        #1;
        s_waitrequest = 1'b0;
      end
      begin
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          check("stall_m1_wait", 32'(m1_waitrequest), 32'd1);
          check("stall_m0_wait", 32'(m0_waitrequest), 32'd1);
          check("stall_m0_rdata", m0_readdata, 32'd0);
        end
        @(negedge clock);
        check("stall_m1_done", 32'(m1_waitrequest), 32'd0);
      end
    join
    check("stall_lat1", l1, 32'd7);
    check("stall_lat0", l0, 32'd8);

    // Reset on the 3rd wait cycle of an m0 write; m0 is re-granted afterwards.
    reset_dut();
    s_waitrequest = 1'b1;
    fork
      master_xfer(0, 1'b1, 32'h400, 4'hF, 32'hDEADBEEF, l0);
      begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("mrst_gnt_before", 32'(grant), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        s_waitrequest = 1'b0;
        @(negedge clock);
        check("mrst_gnt", 32'(grant), 32'd0);
        check("mrst_s_rw", 32'({s_read, s_write}), 32'd0);
        check("mrst_s_addr", s_address, 32'd0);
        check("mrst_s_wdata", s_writedata, 32'd0);
        check("mrst_s_be", 32'(s_byteenable), 32'd0);
        check("mrst_mwait", 32'({m0_waitrequest, m1_waitrequest}), 32'd3);
        @(negedge clock);
        check("mrst_regrant", 32'(grant), 32'd1);
      end
    join
    check("mrst_lat", l0, 32'd6);

`ifdef ARB_TIMEOUT_EN
    // Stuck slave: forced completion on the 16th grant cycle.
    reset_dut();
    s_waitrequest = 1'b1;
    m0_address = 32'h500; m0_byteenable = 4'hF; m0_read = 1'b1;
    @(negedge clock);
    check("to_gnt_c0", 32'(grant), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      check("to_gnt", 32'(grant), 32'd1);
      check("to_wait", 32'(m0_waitrequest), (i == 16) ? 32'd0 : 32'd1);
      check("to_pulse", 32'(timeout), (i == 16) ? 32'd1 : 32'd0);
      if (i == 16) begin
        check("to_rdata", m0_readdata, 32'd0);
        check("to_s_read", 32'(s_read), 32'd0);
      end
    end
    @(posedge clock);
    #1;
    m0_read = 1'b0;
    @(negedge clock);
    check("to_idle", 32'(grant), 32'd0);
    check("to_pulse_end", 32'(timeout), 32'd0);
    s_waitrequest = 1'b0;
`else
    // Without the watchdog a stalled slave stalls the master indefinitely.
    reset_dut();
    s_waitrequest = 1'b1;
    fork
      master_xfer(0, 1'b0, 32'h500, 4'hF, 32'd0, l0);
      begin
        repeat (21) @(posedge clock);
        #1;
        s_waitrequest = 1'b0;
      end
      begin
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
          @(negedge clock);
          check("nto_gnt", 32'(grant), 32'd1);
          check("nto_wait", 32'(m0_waitrequest), 32'd1);
          check("nto_pulse", 32'(timeout), 32'd0);
        end
      end
    join
    check("nto_lat", l0, 32'd22);
`endif

    repeat (2) @(negedge clock);
    check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
